// File: rtl/silu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | silu_pkg: SiLU Q3.5 breakpoints and slope codes, shared by fwd and bwd     |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
package silu_pkg;

   localparam int Q_FRAC = 5;

   localparam logic signed [7:0] SILU_BP_NEG96 = -8'sd96;
   localparam logic signed [7:0] SILU_BP_NEG32 = -8'sd32;
   localparam logic signed [7:0] SILU_BP_POS96 = 8'sd96;

   typedef enum logic [2:0] {
      S0  = 3'd0,
      S8  = 3'd1,
      S16 = 3'd2,
      S28 = 3'd3,
      S32 = 3'd4
   } slope_code_t;

   // Slope magnitude in Q3.5 (32 == 1.0)
   function automatic logic [5:0] slope_value(input slope_code_t code);
      logic [5:0] v;
      case (code)
         S8:      v = 6'd8;
         S16:     v = 6'd16;
         S28:     v = 6'd28;
         S32:     v = 6'd32;
         default: v = 6'd0;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/silu_slope_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | silu_slope_lane: combinational Q3.5 x -> piecewise-linear SiLU slope code  |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module silu_slope_lane
   import silu_pkg::*;
(
   input  logic [7:0]  x,
   output slope_code_t code
);

   logic signed [7:0] w_x;
   assign w_x = x;

   always_comb begin
      code = S0;
      if (w_x < SILU_BP_NEG96)
         code = S0;
      else if (w_x < SILU_BP_NEG32)
         code = S8;
      else if (w_x[7])
         code = S16;
      else if (w_x < SILU_BP_POS96)
         code = S28;
      else
         code = S32;
   end

endmodule
`default_nettype wire

// File: rtl/silu_grad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | silu_grad: 2-stage valid/ready SiLU backward pass, gin = gout * silu'(x)   |
// | Optional macro SILU_GRAD_ROUND_EN: round-half-up before the >>>5 shift.   |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module silu_grad
   import silu_pkg::*;
#(
   parameter int BUS_NUM = 8,
   parameter int CNT_W   = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [BUS_NUM*8-1:0]   x_vec,
   input  logic [BUS_NUM*8-1:0]   gout_vec,
   output logic [BUS_NUM*8-1:0]   gin_vec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CNT_W-1:0]       beat_cnt
);

   slope_code_t              w_code    [BUS_NUM];
   slope_code_t              r_s1_code [BUS_NUM];
   logic [BUS_NUM*8-1:0]     r_s1_gout;
   logic                     r_s1_valid;
   logic [BUS_NUM*8-1:0]     r_gin;
   logic                     r_out_valid;
   logic [CNT_W-1:0]         r_cnt;
   logic [BUS_NUM*8-1:0]     w_gin_next;
   logic                     w_s2_load;
   logic                     w_in_xfer;

   assign w_s2_load = !r_out_valid || out_ready;
   assign in_ready  = !r_s1_valid || w_s2_load;
   assign w_in_xfer = in_valid && in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < BUS_NUM; gi++) begin : g_lane
         logic signed [15:0] w_g16;
         logic signed [15:0] w_s16;
         logic signed [15:0] w_prod;
         logic signed [15:0] w_bias;
         logic signed [15:0] w_shift;
         logic        [7:0]  w_sat;

         silu_slope_lane u_slope (
            .x    (x_vec[8*gi +: 8]),
            .code (w_code[gi])
         );

         assign w_g16  = {{8{r_s1_gout[8*gi+7]}}, r_s1_gout[8*gi +: 8]};
         assign w_s16  = {10'd0, slope_value(r_s1_code[gi])};
         assign w_prod = w_g16 * w_s16;
`ifdef SILU_GRAD_ROUND_EN
         assign w_bias = w_prod + 16'sd16;
`else
         assign w_bias = w_prod;
`endif
         assign w_shift = w_bias >>> Q_FRAC;

         // Unreachable with the current slope set, kept as an overflow guard
         always_comb begin
            w_sat = w_shift[7:0];
            if (w_shift > 16'sd127)
               w_sat = 8'h7F;
            else if (w_shift < -16'sd128)
               w_sat = 8'h80;
         end

         assign w_gin_next[8*gi +: 8] = w_sat;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_gout  <= '0;
         for (int i = 0; i < BUS_NUM; i++)
            r_s1_code[i] <= S0;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_gout  <= gout_vec;
         r_s1_code  <= w_code;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_gin       <= '0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid)
            r_gin <= w_gin_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (r_out_valid && out_ready)
         r_cnt <= r_cnt + 1'b1;
   end

   assign gin_vec   = r_gin;
   assign out_valid = r_out_valid;
   assign beat_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_silu_grad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_silu_grad: directed and random checks of silu_grad against a model     |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_silu_grad;

   localparam int BUS_NUM = 8;
   localparam int CNT_W   = 4;
   localparam int W       = BUS_NUM * 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     x_vec = '0;
   logic [W-1:0]     gout_vec = '0;
   logic [W-1:0]     gin_vec;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] beat_cnt;

   int n_checks = 0;
   int n_errs   = 0;
   int model_cnt = 0;
   int n_pops = 0;
   bit mon_en = 1'b1;
   bit stalled_prev = 1'b0;
   logic [W-1:0] exp_q [$];

   silu_grad #(.BUS_NUM(BUS_NUM), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_vec     (x_vec),
      .gout_vec  (gout_vec),
      .gin_vec   (gin_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: slope from the breakpoint table, real-valued product floored to Q3.5
   function automatic logic [W-1:0] model(input logic [W-1:0] xv, input logic [W-1:0] gv);
      logic [W-1:0] res;
      logic [7:0] xb, gb;
      int x, g, s, p, q;
      res = '0;
      for (int i = 0; i < BUS_NUM; i++) begin
         xb = xv[8*i +: 8];
         gb = gv[8*i +: 8];
         x  = int'($signed(xb));
         g  = int'($signed(gb));
         if (x < -96)      s = 0;
         else if (x < -32) s = 8;
         else if (x < 0)   s = 16;
         else if (x < 96)  s = 28;
         else              s = 32;
         p = g * s;
`ifdef SILU_GRAD_ROUND_EN
         p = p + 16;
`endif
         q = (p >= 0) ? p / 32 : -((-p + 31) / 32);
         if (q > 127)  q = 127;
         if (q < -128) q = -128;
         res[8*i +: 8] = 8'(q);
      end
      return res;
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (stalled_prev)
            check("hold_valid", {{(W-1){1'b0}}, out_valid}, 1);
         if (out_valid && out_ready) begin
            check("beat_cnt", W'(beat_cnt), W'(model_cnt % 16));
            model_cnt++;
            n_pops++;
            if (exp_q.size() == 0)
               check("out_without_beat", {{(W-1){1'b0}}, out_valid}, 0);
            else
               check("gin", gin_vec, exp_q.pop_front());
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(x_vec, gout_vec));
         stalled_prev = out_valid && !out_ready;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [W-1:0] xv, input logic [W-1:0] gv);
      int n;
      n = 0;
      x_vec    = xv;
      gout_vec = gv;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", {{(W-1){1'b0}}, in_ready}, 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic one_beat(input string tag, input logic [W-1:0] xv,
                           input logic [W-1:0] gv, input logic [W-1:0] expv);
      out_ready = 1'b1;
      send(xv, gv);
      check({tag, "_lat1"}, {{(W-1){1'b0}}, out_valid}, 0);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {{(W-1){1'b0}}, out_valid}, 1);
      check({tag, "_gin"}, gin_vec, expv);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_vec(input bit near_bp);
      logic [W-1:0] v;
      logic [7:0] b;
      int bps[8] = '{-97, -96, -33, -32, -1, 0, 95, 96};
      for (int i = 0; i < BUS_NUM; i++) begin
         if (near_bp && ($urandom % 2 == 0)) b = 8'(bps[$urandom % 8]);
         else                                b = 8'($urandom);
         v[8*i +: 8] = b;
      end
      return v;
   endfunction

   initial begin
      logic [W-1:0] xv, gv, ev, b0;
      int xs[8] = '{-97, -96, -33, -32, -1, 0, 95, 96};
      int es[8] = '{0, 16, 16, 32, 32, 56, 56, 64};
      int sent, guard, pops0;
      bit xfer;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {{(W-1){1'b0}}, out_valid}, 0);
      check("rst_gin", gin_vec, 0);
      check("rst_beat_cnt", W'(beat_cnt), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", {{(W-1){1'b0}}, in_ready}, 1);

      // Plain beat
      one_beat("t1", {BUS_NUM{8'd64}}, {BUS_NUM{8'd32}}, {BUS_NUM{8'd28}});
      check("t1_cnt", W'(beat_cnt), 1);

      // Breakpoint lanes
      for (int i = 0; i < BUS_NUM; i++) begin
         xv[8*i +: 8] = 8'(xs[i]);
         ev[8*i +: 8] = 8'(es[i]);
      end
      one_beat("t2", xv, {BUS_NUM{8'd64}}, ev);

      // Rounding / extreme negative
`ifdef SILU_GRAD_ROUND_EN
      one_beat("t3a", {BUS_NUM{8'hFF}}, {BUS_NUM{8'hFD}}, {BUS_NUM{8'hFF}});
`else
      one_beat("t3a", {BUS_NUM{8'hFF}}, {BUS_NUM{8'hFD}}, {BUS_NUM{8'hFE}});
`endif
      one_beat("t3b", {BUS_NUM{8'd100}}, {BUS_NUM{8'h80}}, {BUS_NUM{8'h80}});

      // Backpressure: 5 beats, sink stalled after the first
      pops0 = n_pops;
      b0 = rand_vec(1'b0);
      gv = rand_vec(1'b0);
      out_ready = 1'b1;
      fork
         begin
            send(b0, gv);
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++) send(rand_vec(1'b1), rand_vec(1'b0));
         end
         begin
            repeat (8) @(posedge clk);
            #2;
            check("bp_in_ready", {{(W-1){1'b0}}, in_ready}, 0);
            check("bp_out_valid", {{(W-1){1'b0}}, out_valid}, 1);
            check("bp_gin_held", gin_vec, model(b0, gv));
            out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      check("bp_pops", W'(n_pops - pops0), 5);
      check("bp_cnt", W'(beat_cnt), W'(model_cnt % 16));
      check("bp_drained", W'(exp_q.size()), 0);

      // Reset during a stall with two beats in flight
      out_ready = 1'b0;
      send(rand_vec(1'b0), rand_vec(1'b0));
      send(rand_vec(1'b0), rand_vec(1'b0));
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {{(W-1){1'b0}}, out_valid}, 0);
      check("mid_rst_gin", gin_vec, 0);
      check("mid_rst_cnt", W'(beat_cnt), 0);
      exp_q.delete();
      model_cnt = 0;
      stalled_prev = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
      mon_en = 1'b1;

      // Random stream
      sent = 0;
      guard = 0;
      while (sent < 10000 && guard < 60000) begin
         @(negedge clk);
         xfer = in_valid && in_ready;
         if (xfer) sent++;
         @(posedge clk);
         #1;
         guard++;
         out_ready = ($urandom % 4) != 0;
         if (xfer || !in_valid) begin
            if (sent < 10000 && ($urandom % 4) != 0) begin
               in_valid = 1'b1;
               x_vec    = rand_vec(1'b1);
               gout_vec = rand_vec(1'b0);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("rand_sent", W'(sent), 10000);
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check("rand_drained", W'(exp_q.size()), 0);
      check("rand_cnt", W'(beat_cnt), W'(model_cnt % 16));

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/silu_grad.md
Name: silu_grad

Overview:
- Backward-pass counterpart of the vector SiLU activation: grad_in[i] = grad_out[i] * silu'(x[i]).
- silu' is the exact slope of the forward piecewise-linear SiLU approximation.
- Operates on BUS_NUM lanes of signed 8-bit Q3.5 data, five fractional bits.
- Sits in the vector engine activation path for training or fine-tuning.
- 2-stage valid/ready pipeline with full backpressure.

Parameters:
- BUS_NUM, 8: number of lanes per vector beat.
- CNT_W, 16: width of the accepted-output beat counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  x_vec/gout_vec valid.
- in_ready  output  1  block can accept a beat this cycle.
- x_vec  input  8 x BUS_NUM (signed array)  forward-pass activation input, Q3.5.
- gout_vec  input  8 x BUS_NUM (signed array)  upstream gradient, Q3.5.
- gin_vec  output  8 x BUS_NUM (signed array)  downstream gradient, Q3.5.
- out_valid  output  1  gin_vec valid.
- out_ready  input  1  consumer accepts gin_vec.
- beat_cnt  output  CNT_W  number of completed output transfers, wraps modulo 2^CNT_W.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Slope code per lane, in Q3.5, from x:
  - x < -96: slope 0.
  - -96 <= x < -32: slope 8 (0.25).
  - -32 <= x < 0: slope 16 (0.5).
  - 0 <= x < 96: slope 28 (0.875).
  - x >= 96: slope 32 (1.0).
  - Boundaries: -96 is slope 8, -32 is slope 16, 0 is slope 28, 96 is slope 32.
- Stage 1 (S1), on input transfer:
  - Registers a 3-bit slope code per lane plus gout per lane.
  - Sets s1_valid.
- Stage 2 (S2), when S1 advances:
  - prod = gout * slope, 16-bit signed.
  - gin = prod >>> 5, arithmetic (floor), then saturated to [-128, 127].
  - Saturation never triggers with these slopes but is required as a guard.
  - Registers gin_vec; sets out_valid.
- Advance rules:
  - S2 loads when !out_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || S2 loads this cycle.
  - Combinational path out_ready -> in_ready is permitted.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput 1 beat/cycle.
- Stall: while out_valid && !out_ready, gin_vec and out_valid are held stable and S1 holds. The block never drops or duplicates a beat.
- Valid clear:
  - If S1 is empty and S2 fires, out_valid clears next cycle.
  - If no input transfer occurs while S1 advances, s1_valid clears.
- Simultaneous input transfer and S1 advance: S1 takes the new beat with no bubble.
- beat_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset (async, any time, including mid-stall):
  - s1_valid=0, out_valid=0, gin_vec all 0, beat_cnt=0, S1 data 0.
  - in_ready=1 one cycle after rst deasserts, since S1 is empty.
  - In-flight beats are discarded.

Optional Feature:
- Macro SILU_GRAD_ROUND_EN.
- Defined: add 16 to prod before the >>>5 (round-half-up), then saturate.
- Undefined: plain arithmetic shift (floor).
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package silu_pkg:
  - Q_FRAC=5.
  - Breakpoint constants SILU_BP_NEG96=-96, SILU_BP_NEG32=-32, SILU_BP_POS96=96.
  - Slope enum/typedef slope_code_t (3-bit: S0, S8, S16, S28, S32) with slope values.
  - Shared with the forward silu so both stay consistent.
- One natural sub-module: silu_slope_lane.
  - Combinational per-lane x -> slope_code.
  - Instantiated BUS_NUM times in S1.
- Multiply/shift/saturate stays inline in S2.

Test Plan:
1. Unstalled, out_ready=1, all lanes x=64, g=32 -> 2 cycles later out_valid=1, gin=28 all lanes; beat_cnt=1.
2. Boundary lanes x={-97,-96,-33,-32,-1,0,95,96}, g=64 -> gin={0,16,16,32,32,56,56,64}.
3. Rounding: x=-1, g=-3 -> gin=-2 without macro, -1 with SILU_GRAD_ROUND_EN; x=100, g=-128 -> -128 in both builds.
4. Backpressure:
   - Stream 5 beats with out_ready held 0 after beat 1.
   - in_ready drops after S1 fills; gin_vec stays stable.
   - On out_ready=1, all 5 beats emerge in order, no loss or duplication; beat_cnt=5.
5. Reset asserted during a stall with 2 beats in flight -> out_valid=0, gin=0, beat_cnt=0 immediately; in_ready=1 after release.
6. Random streams with random in_valid/out_ready against a reference model for 10k beats; beat_cnt with CNT_W=4 wraps 15->0.
